// File: rtl/fifo_ctrl_flex_if.sv
// Handshake and status bundle between a FIFO user and fifo_ctrl_flex.
// master: requester side (drives rd/wr/flush/clr_err); slave: the controller.
interface fifo_ctrl_flex_if #(
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  rd;
    logic                  wr;
    logic                  flush;
    logic                  clr_err;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output rd, wr, flush, clr_err,
        input  wr_en, rd_en, w_addr, r_addr, count, empty, full,
               almost_empty, almost_full, overflow, underflow
    );

    modport slave (
        input  rd, wr, flush, clr_err,
        output wr_en, rd_en, w_addr, r_addr, count, empty, full,
               almost_empty, almost_full, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl_flex.sv
// Pointer/occupancy controller for an external register-file FIFO with thresholds and flush.
// Define FIFO_CTRL_FLEX_ERR_EN to build the sticky overflow/underflow flags.
module fifo_ctrl_flex #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    fifo_ctrl_flex_if.slave        bus
);
    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] r_w_ptr;
    logic [ADDR_WIDTH-1:0] r_r_ptr;
    logic [CW-1:0]         r_count;
    logic [ADDR_WIDTH-1:0] w_w_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_r_ptr_nxt;
    logic [CW-1:0]         w_count_nxt;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_ovf_evt;
    logic                  w_udf_evt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // A write at full is accepted only when a simultaneous pop frees the slot.
    assign w_wr_en   = bus.wr & (~w_full | bus.rd) & ~bus.flush;
    assign w_rd_en   = bus.rd & ~w_empty & ~bus.flush;
    assign w_ovf_evt = bus.wr & ~w_wr_en & ~bus.flush;
    assign w_udf_evt = bus.rd & ~w_rd_en & ~bus.flush;

    always_comb begin
        w_w_ptr_nxt = r_w_ptr;
        w_r_ptr_nxt = r_r_ptr;
        w_count_nxt = r_count;
        if (bus.flush) begin
            w_w_ptr_nxt = '0;
            w_r_ptr_nxt = '0;
            w_count_nxt = '0;
        end else begin
            if (w_wr_en) w_w_ptr_nxt = r_w_ptr + ADDR_WIDTH'(1);
            if (w_rd_en) w_r_ptr_nxt = r_r_ptr + ADDR_WIDTH'(1);
            case ({w_wr_en, w_rd_en})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_w_ptr <= '0;
            r_r_ptr <= '0;
            r_count <= '0;
        end else begin
            r_w_ptr <= w_w_ptr_nxt;
            r_r_ptr <= w_r_ptr_nxt;
            r_count <= w_count_nxt;
        end
    end

`ifdef FIFO_CTRL_FLEX_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky flags; a new error in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt)        r_overflow  <= 1'b1;
            else if (bus.clr_err) r_overflow  <= 1'b0;
            if (w_udf_evt)        r_underflow <= 1'b1;
            else if (bus.clr_err) r_underflow <= 1'b0;
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`else
    logic w_unused_err;
    assign w_unused_err  = bus.clr_err ^ w_ovf_evt ^ w_udf_evt;
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.wr_en        = w_wr_en;
    assign bus.rd_en        = w_rd_en;
    assign bus.w_addr       = r_w_ptr;
    assign bus.r_addr       = r_r_ptr;
    assign bus.count        = r_count;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_full  = (r_count >= CW'(AF_THRESH));
    assign bus.almost_empty = (r_count <= CW'(AE_THRESH));
endmodule

// File: tb/tb_fifo_ctrl_flex.sv
// Directed self-checking bench for fifo_ctrl_flex at DEPTH=4, AF_THRESH=3, AE_THRESH=1.
module tb_fifo_ctrl_flex;
    localparam int unsigned AW = 2;

`ifdef FIFO_CTRL_FLEX_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    fifo_ctrl_flex_if #(.ADDR_WIDTH(AW)) bus_if ();

    fifo_ctrl_flex #(
        .ADDR_WIDTH(AW),
        .AF_THRESH (3),
        .AE_THRESH (1)
    ) u_dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs mid-cycle so combinational strobes can be checked before the edge.
    task automatic drive(input logic wr, input logic rd, input logic fl, input logic clr);
        @(negedge clk);
        bus_if.wr      = wr;
        bus_if.rd      = rd;
        bus_if.flush   = fl;
        bus_if.clr_err = clr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input int cnt, input int wa, input int ra);
        check_eq({tag, ".count"}, 32'(bus_if.count), 32'(cnt));
        check_eq({tag, ".w_addr"}, 32'(bus_if.w_addr), 32'(wa));
        check_eq({tag, ".r_addr"}, 32'(bus_if.r_addr), 32'(ra));
        check_eq({tag, ".empty"}, 32'(bus_if.empty), 32'(cnt == 0));
        check_eq({tag, ".full"}, 32'(bus_if.full), 32'(cnt == 4));
        check_eq({tag, ".af"}, 32'(bus_if.almost_full), 32'(cnt >= 3));
        check_eq({tag, ".ae"}, 32'(bus_if.almost_empty), 32'(cnt <= 1));
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset_n        = 1'b0;
        bus_if.wr      = 1'b0;
        bus_if.rd      = 1'b0;
        bus_if.flush   = 1'b0;
        bus_if.clr_err = 1'b0;
        #12;
        check_status("reset", 0, 0, 0);
        check_eq("reset.ovf", 32'(bus_if.overflow), 32'd0);
        check_eq("reset.udf", 32'(bus_if.underflow), 32'd0);
        check_eq("reset.wr_en", 32'(bus_if.wr_en), 32'd0);
        check_eq("reset.rd_en", 32'(bus_if.rd_en), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Fill: count 1..4, write pointer wraps 3 -> 0.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            check_eq("fill.wr_en", 32'(bus_if.wr_en), 32'd1);
            tick();
            check_status("fill", i, i % 4, 0);
        end

        // Write at full is rejected.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("ovf.wr_en", 32'(bus_if.wr_en), 32'd0);
        tick();
        check_status("ovf", 4, 0, 0);
        check_eq("ovf.flag", 32'(bus_if.overflow), 32'(ERR_ON));
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("clr.ovf", 32'(bus_if.overflow), 32'd0);

        // Sustained read+write at full: both pointers advance, count stays 4.
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            check_eq("rw_full.wr_en", 32'(bus_if.wr_en), 32'd1);
            check_eq("rw_full.rd_en", 32'(bus_if.rd_en), 32'd1);
            tick();
            check_eq("rw_full.count", 32'(bus_if.count), 32'd4);
        end
        check_status("rw_full", 4, 2, 2);
        check_eq("rw_full.ovf", 32'(bus_if.overflow), 32'd0);

        // Drain to empty.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            check_eq("drain.rd_en", 32'(bus_if.rd_en), 32'd1);
            tick();
            check_status("drain", 4 - i, 2, (2 + i) % 4);
        end
        check_eq("drain.udf", 32'(bus_if.underflow), 32'd0);

        // Read+write at empty: write accepted, read rejected.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("rw_empty.wr_en", 32'(bus_if.wr_en), 32'd1);
        check_eq("rw_empty.rd_en", 32'(bus_if.rd_en), 32'd0);
        tick();
        check_status("rw_empty", 1, 3, 2);
        check_eq("rw_empty.udf", 32'(bus_if.underflow), 32'(ERR_ON));

        // Two more writes to reach count 3, then flush with a write.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_status("pre_flush", 3, 1, 2);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("flush.wr_en", 32'(bus_if.wr_en), 32'd0);
        tick();
        check_status("flush", 0, 0, 0);
        check_eq("flush.udf", 32'(bus_if.underflow), 32'(ERR_ON));
        check_eq("flush.ovf", 32'(bus_if.overflow), 32'd0);

        // Read at empty with clr_err: the new error wins.
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("udf_clr.rd_en", 32'(bus_if.rd_en), 32'd0);
        tick();
        check_status("udf_clr", 0, 0, 0);
        check_eq("udf_clr.udf", 32'(bus_if.underflow), 32'(ERR_ON));

        // Async reset mid-operation at count 2.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_status("pre_rst", 2, 2, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        check_status("async_rst", 0, 0, 0);
        check_eq("async_rst.udf", 32'(bus_if.underflow), 32'd0);
        check_eq("async_rst.ovf", 32'(bus_if.overflow), 32'd0);
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_status("post_rst", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_ctrl_flex.md
# fifo_ctrl_flex

Parametrised pointer and status controller for the MMIO FIFOs, the successor to the basic FIFO controller. It drives the read/write addresses of an external register-file FIFO and tracks an exact occupancy count. It also provides almost-full/almost-empty thresholds, a synchronous flush, and optional sticky overflow/underflow error flags. It sits between a UART/SPI datapath (writer), the MMIO read/write strobes (reader) and the FIFO storage array.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: address width; `DEPTH = 2**ADDR_WIDTH` entries, all usable.
- `AF_THRESH`, default `DEPTH-2`: `almost_full` asserts when `count >= AF_THRESH`; legal range 1..DEPTH.
- `AE_THRESH`, default 1: `almost_empty` asserts when `count <= AE_THRESH`; legal range 0..DEPTH-1.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `rd`, in, 1: read (pop) request.
- `wr`, in, 1: write (push) request.
- `flush`, in, 1: synchronous clear of contents.
- `clr_err`, in, 1: synchronous clear of the sticky error flags.
- `wr_en`, out, 1: qualified storage write strobe; combinational, equal to `wr & (~full | rd)`.
- `rd_en`, out, 1: qualified pop; combinational, equal to `rd & ~empty`.
- `w_addr`, out, ADDR_WIDTH: write pointer (the slot written when `wr_en` is high).
- `r_addr`, out, ADDR_WIDTH: read pointer (the oldest entry).
- `count`, out, ADDR_WIDTH+1: occupancy, 0..DEPTH.
- `empty`, out, 1: high when `count == 0`.
- `full`, out, 1: high when `count == DEPTH`.
- `almost_empty`, out, 1: threshold flag.
- `almost_full`, out, 1: threshold flag.
- `overflow`, out, 1: sticky; set when a write is rejected.
- `underflow`, out, 1: sticky; set when a read is rejected.

## Operation
- State: `w_ptr`, `r_ptr` (ADDR_WIDTH bits each, wrap modulo DEPTH), `count_reg` (ADDR_WIDTH+1 bits), and the error flags. All status outputs decode from registered state only.
- Per-cycle priority: `flush` first, then normal `{wr,rd}` handling.
- Flush: `w_ptr` = `r_ptr` = 0 and `count` = 0. `rd` and `wr` are ignored in that cycle, and `wr_en`/`rd_en` are forced to 0. Flush does not touch the error flags.
- `{wr,rd}` = 01:
  - If not empty: `r_ptr` increments and `count` decrements.
  - If empty: no change, and `underflow` sets.
- `{wr,rd}` = 10:
  - If not full: `w_ptr` increments and `count` increments.
  - If full: no change, and `overflow` sets.
- `{wr,rd}` = 11:
  - Empty: the write is accepted and the read is rejected. `w_ptr` increments, `count` becomes 1, and `underflow` sets.
  - Full: both are accepted. Both pointers increment, `count` stays at DEPTH and `full` stays high; no overflow.
  - Otherwise: both pointers increment and `count` is unchanged.
- `{wr,rd}` = 00: hold.
- `clr_err`: clears both error flags. If a new error event occurs in the same cycle, the set wins.
- Pointer wrap: DEPTH-1 increments to 0. `full` and `empty` come from `count`, never from pointer equality.

## Timing
- Reset (async assert, sync-safe release): pointers = 0, `count` = 0, `empty` = 1, `full` = 0, `almost_empty` = 1, `almost_full` = 0 (for AF_THRESH ≥ 1), `overflow` = 0, `underflow` = 0. With `rd`/`wr` low, `wr_en` = 0 and `rd_en` = 0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Latency: a push or pop at edge N is reflected in `count`, the pointers and all flags after edge N (i.e. in cycle N+1).
- `wr_en`/`rd_en` are valid in the same cycle as the request and are intended to gate the storage write and the reader's data capture.
- Sustained `rd` & `wr` at full runs at 1 entry per cycle in each direction.
- Read data from storage at `r_addr` is valid in the current cycle, which gives first-word-fall-through behaviour when storage reads are combinational.

## Configuration
- Macro: `FIFO_CTRL_FLEX_ERR_EN`.
- Defined: sticky `overflow`/`underflow` logic and `clr_err` behave as described above.
- Undefined: `overflow` and `underflow` are tied to 0 and `clr_err` is ignored. No error registers are synthesised. All other behaviour is identical.

## Test plan
All scenarios use ADDR_WIDTH=2 (DEPTH=4), AF_THRESH=3, AE_THRESH=1.
- Release reset, then write 4 cycles -> `count` 1,2,3,4. `almost_full` rises when `count` = 3; `full` = 1 after the 4th write; `w_addr` wraps 3→0.
- At `full`, `wr` only -> `wr_en` = 0, `count` stays 4, `overflow` = 1 (macro on) or 0 (macro off). Then `clr_err` for one cycle -> `overflow` = 0.
- At `full`, hold `rd` & `wr` for 6 cycles -> `count` stays 4, both pointers advance by 6 mod 4 = 2, no overflow.
- At `empty`, `rd` & `wr` together -> `wr_en` = 1, `rd_en` = 0, `count` = 1, `underflow` = 1, `r_addr` unchanged.
- With `count` = 3, assert `flush` together with `wr` -> `count` = 0, `empty` = 1, pointers = 0, `wr_en` = 0, and error flags unchanged.
- With `count` = 2, pulse `reset_n` low between clock edges -> all outputs take their reset values immediately, before the next edge.
